// File: rtl/load_store_unit.sv
// RV32I load/store unit: one transaction at a time over a req/gnt/rvalid data bus.
// Optional macro LSU_MISALIGN_TRAP_EN turns illegal accesses into error responses instead of truncated bus accesses.
module load_store_unit (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        req_valid_in,
  output logic        req_ready_o,
  input  logic        mem_wr_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  rd_in,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_err_o,
  output logic [1:0]  state_dbg_o
);

  // Handshakes: a request transfers on the rising edge where req_valid_in && req_ready_o;
  // a bus request transfers on the edge where dmem_req_o && dmem_gnt_in; read data is taken
  // only on an edge where dmem_rvalid_in is high in WAIT_RESP; resp_valid_o is a one-cycle pulse.

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_RESP = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic [1:0]  req_off;
  logic [1:0]  eff_size;
  logic [1:0]  eff_off;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] rdata_shift;
  logic [31:0] load_ext;

  assign req_off = addr_in[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_illegal;
  assign req_illegal = (load_size_in == 2'b01 && req_off[0]) ||
                       (load_size_in == 2'b10 && req_off != 2'b00) ||
                       (load_size_in == 2'b11);
  assign eff_size = load_size_in;
  assign eff_off  = req_off;
`else
  // Illegal accesses are forced to natural alignment; the reserved size behaves as word.
  always_comb begin
    eff_size = load_size_in;
    eff_off  = req_off;
    case (load_size_in)
      2'b00:   eff_off = req_off;
      2'b01:   eff_off = {req_off[1], 1'b0};
      default: begin
        eff_size = 2'b10;
        eff_off  = 2'b00;
      end
    endcase
  end
`endif

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = wdata_in;
    case (eff_size)
      2'b00: begin
        req_be    = 4'b0001 << eff_off;
        req_wdata = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        req_be    = 4'b0011 << {eff_off[1], 1'b0};
        req_wdata = {2{wdata_in[15:0]}};
      end
      default: begin
        req_be    = 4'b1111;
        req_wdata = wdata_in;
      end
    endcase
    if (!mem_wr_req_in) req_wdata = 32'h0;
  end

  assign rdata_shift = dmem_rdata_in >> {off_q, 3'b000};

  always_comb begin
    load_ext = rdata_shift;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, rdata_shift[7:0]}
                                : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, rdata_shift[15:0]}
                                : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_in) begin
          we_d    = mem_wr_req_in;
          size_d  = eff_size;
          uns_d   = load_unsigned_in;
          off_d   = eff_off;
          addr_d  = addr_in[31:2];
          be_d    = req_be;
          wdata_d = req_wdata;
          rd_d    = rd_in;
          data_d  = 32'h0;
          err_d   = 1'b0;
          state_d = S_REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_illegal) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_REQ: begin
        if (dmem_gnt_in) state_d = we_q ? S_DONE : S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (dmem_rvalid_in) begin
          data_d  = load_ext;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= 30'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rd_q    <= 5'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Bus and response fields are masked so idle outputs read as zero.
  assign req_ready_o  = (state_q == S_IDLE);
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = dmem_req_o & we_q;
  assign dmem_addr_o  = dmem_req_o ? {addr_q, 2'b00} : 32'h0;
  assign dmem_be_o    = dmem_req_o ? be_q : 4'h0;
  assign dmem_wdata_o = dmem_req_o ? wdata_q : 32'h0;
  assign resp_valid_o = (state_q == S_DONE);
  assign resp_data_o  = resp_valid_o ? data_q : 32'h0;
  assign resp_rd_o    = resp_valid_o ? rd_q : 5'h0;
  assign resp_err_o   = resp_valid_o & err_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit: a driver issues requests, a memory process
// answers the bus, and monitors compare bus fields and responses against expected queues.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        wr_req = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [4:0]  rd = 5'h0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic [1:0]  state_dbg;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] cyc = 16'h0;

  // {expected cycle[15:0], err, rd[4:0], data[31:0]}
  logic [53:0] exp_q[$];
  // {we, addr[31:0], be[3:0], wdata[31:0]}
  logic [68:0] bus_q[$];

  typedef struct packed {
    logic [7:0]  gd;
    logic [7:0]  rvd;
    logic [31:0] rdata;
    logic        load;
    logic        early;
  } mem_cfg_t;
  mem_cfg_t cfg_q[$];

  logic [53:0] mon_e;
  logic [68:0] mon_b;

  load_store_unit dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .req_valid_in     (req_valid),
    .req_ready_o      (req_ready),
    .mem_wr_req_in    (wr_req),
    .load_size_in     (size),
    .load_unsigned_in (uns),
    .addr_in          (addr),
    .wdata_in         (wdata),
    .rd_in            (rd),
    .dmem_req_o       (dmem_req),
    .dmem_we_o        (dmem_we),
    .dmem_addr_o      (dmem_addr),
    .dmem_be_o        (dmem_be),
    .dmem_wdata_o     (dmem_wdata),
    .dmem_gnt_in      (dmem_gnt),
    .dmem_rvalid_in   (dmem_rvalid),
    .dmem_rdata_in    (dmem_rdata),
    .resp_valid_o     (resp_valid),
    .resp_data_o      (resp_data),
    .resp_rd_o        (resp_rd),
    .resp_err_o       (resp_err),
    .state_dbg_o      (state_dbg)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response and bus monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got resp data %h rd %0d, required no response", resp_data, resp_rd);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_cycle", {16'h0, cyc}, {16'h0, mon_e[53:38]});
          chk("resp_err", {31'h0, resp_err}, {31'h0, mon_e[37]});
          chk("resp_rd", {27'h0, resp_rd}, {27'h0, mon_e[36:32]});
          chk("resp_data", resp_data, mon_e[31:0]);
        end
      end
      if (dmem_req) begin
        if (bus_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_bus_req: got addr %h be %b, required no bus request", dmem_addr, dmem_be);
        end else begin
          mon_b = bus_q[0];
          chk("bus_we", {31'h0, dmem_we}, {31'h0, mon_b[68]});
          chk("bus_addr", dmem_addr, mon_b[67:36]);
          chk("bus_be", {28'h0, dmem_be}, {28'h0, mon_b[35:32]});
          chk("bus_wdata", dmem_wdata, mon_b[31:0]);
          if (dmem_gnt) void'(bus_q.pop_front());
        end
      end else begin
        chk("bus_idle_zero", dmem_addr | dmem_wdata | {27'h0, dmem_be, dmem_we}, 32'h0);
      end
    end
  end

  // Memory responder: one config entry per issued bus request
  initial begin
    mem_cfg_t c;
    forever begin
      @(posedge clk); #1;
      if (dmem_req && cfg_q.size() > 0) begin
        c = cfg_q.pop_front();
        for (int i = 0; i < int'(c.gd); i++) begin @(posedge clk); #1; end
        dmem_gnt = 1'b1;
        if (c.early) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = 32'hBAD0BAD0;
        end
        @(posedge clk); #1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        if (c.load) begin
          for (int i = 0; i < int'(c.rvd); i++) begin @(posedge clk); #1; end
          dmem_rvalid = 1'b1;
          dmem_rdata  = c.rdata;
          @(posedge clk); #1;
          dmem_rvalid = 1'b0;
          dmem_rdata  = 32'h0;
        end
      end
    end
  end

  task automatic push_mem(input int gd, input int rvd, input logic [31:0] rdat,
                          input logic load, input logic early);
    mem_cfg_t c;
    c.gd    = 8'(gd);
    c.rvd   = 8'(rvd);
    c.rdata = rdat;
    c.load  = load;
    c.early = early;
    cfg_q.push_back(c);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'h0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      bus_q.delete();
      cfg_q.delete();
    end
  endtask

  // Driver: called at #1 after a rising edge while the DUT is idle
  task automatic txn(input logic we, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                     input logic [31:0] rdat, input int gd, input int rvd, input logic early,
                     input logic on_bus, input logic [31:0] e_addr, input logic [3:0] e_be,
                     input logic [31:0] e_wdata, input logic [31:0] e_data,
                     input logic e_err, input int lat);
    req_valid = 1'b1;
    wr_req    = we;
    size      = sz;
    uns       = un;
    addr      = a;
    wdata     = wd;
    rd        = r;
    exp_q.push_back({cyc + 16'(lat), e_err, r, e_data});
    if (on_bus) begin
      bus_q.push_back({we, e_addr, e_be, e_wdata});
      push_mem(gd, rvd, rdat, !we, early);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
  endtask

  initial begin
    logic [15:0] acc;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset_bus_req", {31'h0, dmem_req}, 32'h0);
    chk("reset_resp_fields", resp_data | {26'h0, resp_rd, resp_err}, 32'h0);
    chk("reset_state", {30'h0, state_dbg}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // we size un addr wdata rd rdata gd rvd early bus e_addr e_be e_wdata e_data e_err lat
    txn(1, 2'b00, 0, 32'h0000_1003, 32'h0000_00A5, 5'd3, 32'h0, 0, 0, 0,
        1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0, 2);
    txn(0, 2'b00, 0, 32'h0000_2001, 32'h0, 5'd4, 32'h0000_F000, 0, 0, 0,
        1, 32'h0000_2000, 4'b0010, 32'h0, 32'hFFFF_FFF0, 0, 3);
    txn(0, 2'b00, 1, 32'h0000_2001, 32'h0, 5'd5, 32'h0000_F000, 0, 0, 0,
        1, 32'h0000_2000, 4'b0010, 32'h0, 32'h0000_00F0, 0, 3);
    txn(0, 2'b01, 0, 32'h0000_2002, 32'h0, 5'd6, 32'h8000_1234, 3, 0, 0,
        1, 32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8000, 0, 6);
    txn(1, 2'b01, 0, 32'h0000_4006, 32'hFFFF_BEEF, 5'd7, 32'h0, 1, 0, 0,
        1, 32'h0000_4004, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0, 3);
    txn(1, 2'b10, 0, 32'h0000_5000, 32'h1234_5678, 5'd8, 32'h0, 0, 0, 0,
        1, 32'h0000_5000, 4'b1111, 32'h1234_5678, 32'h0, 0, 2);
    // rvalid together with the grant must be ignored
    txn(0, 2'b01, 1, 32'h0000_6000, 32'h0, 5'd10, 32'h1234_9ABC, 0, 0, 1,
        1, 32'h0000_6000, 4'b0011, 32'h0, 32'h0000_9ABC, 0, 3);
    txn(0, 2'b00, 0, 32'h0000_6003, 32'h0, 5'd11, 32'h7F00_0000, 0, 2, 0,
        1, 32'h0000_6000, 4'b1000, 32'h0, 32'h0000_007F, 0, 5);
    txn(1, 2'b00, 0, 32'h0000_9002, 32'h0000_003C, 5'd12, 32'h0, 0, 0, 0,
        1, 32'h0000_9000, 4'b0100, 32'h3C3C_3C3C, 32'h0, 0, 2);
`ifdef LSU_MISALIGN_TRAP_EN
    txn(0, 2'b10, 0, 32'h0000_3002, 32'h0, 5'd13, 32'h0, 0, 0, 0,
        0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
    txn(0, 2'b11, 0, 32'h0000_7000, 32'h0, 5'd14, 32'h0, 0, 0, 0,
        0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
    txn(0, 2'b01, 0, 32'h0000_8001, 32'h0, 5'd15, 32'h0, 0, 0, 0,
        0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
    txn(1, 2'b10, 0, 32'h0000_8003, 32'hFFFF_FFFF, 5'd16, 32'h0, 0, 0, 0,
        0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1);
`else
    txn(0, 2'b10, 0, 32'h0000_3002, 32'h0, 5'd13, 32'hDEAD_BEEF, 0, 0, 0,
        1, 32'h0000_3000, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, 3);
    txn(0, 2'b11, 0, 32'h0000_7000, 32'h0, 5'd14, 32'hCAFE_F00D, 0, 0, 0,
        1, 32'h0000_7000, 4'b1111, 32'h0, 32'hCAFE_F00D, 0, 3);
    txn(0, 2'b01, 0, 32'h0000_8001, 32'h0, 5'd15, 32'h0000_8001, 0, 0, 0,
        1, 32'h0000_8000, 4'b0011, 32'h0, 32'hFFFF_8001, 0, 3);
    txn(1, 2'b10, 0, 32'h0000_8003, 32'h0102_0304, 5'd16, 32'h0, 0, 0, 0,
        1, 32'h0000_8000, 4'b1111, 32'h0102_0304, 32'h0, 0, 2);
`endif

    // Reset pulsed during WAIT_RESP; the late rvalid must not produce a response
    req_valid = 1'b1;
    wr_req    = 1'b0;
    size      = 2'b10;
    uns       = 1'b0;
    addr      = 32'h0000_C000;
    rd        = 5'd9;
    bus_q.push_back({1'b0, 32'h0000_C000, 4'b1111, 32'h0});
    push_mem(0, 4, 32'h55AA_55AA, 1, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wait_resp_state", {30'h0, state_dbg}, 32'h2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("mid_reset_ready", {31'h0, req_ready}, 32'h1);
    chk("mid_reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("post_reset_ready", {31'h0, req_ready}, 32'h1);
    chk("post_reset_state", {30'h0, state_dbg}, 32'h0);
    chk("post_reset_bus_q", 32'(bus_q.size()), 32'h0);

    // Back-to-back: second request held high while the first waits two cycles for grant
    req_valid = 1'b1;
    wr_req    = 1'b1;
    size      = 2'b10;
    uns       = 1'b0;
    addr      = 32'h0000_A000;
    wdata     = 32'h1122_3344;
    rd        = 5'd1;
    acc       = cyc;
    exp_q.push_back({acc + 16'd4, 1'b0, 5'd1, 32'h0});
    bus_q.push_back({1'b1, 32'h0000_A000, 4'b1111, 32'h1122_3344});
    push_mem(2, 0, 32'h0, 0, 0);
    exp_q.push_back({acc + 16'd8, 1'b0, 5'd2, 32'h0000_0055});
    bus_q.push_back({1'b0, 32'h0000_B000, 4'b0010, 32'h0});
    push_mem(0, 0, 32'h0000_5500, 1, 0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    size   = 2'b00;
    uns    = 1'b1;
    addr   = 32'h0000_B001;
    wdata  = 32'hFFFF_FFFF;
    rd     = 5'd2;
    chk("b2b_ready_low", {31'h0, req_ready}, 32'h0);
    repeat (4) begin @(posedge clk); #1; end
    chk("b2b_ready_after_done", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    repeat (3) begin @(posedge clk); #1; end
    chk("final_bus_q_empty", 32'(bus_q.size()), 32'h0);
    chk("final_exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
